seq_detect_ctrl: RTL and testbench

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_ctrl.sv | 115 +++++++++++
 tb/tb_seq_detect_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Serial 4-bit pattern detector with word-in / count-out valid/ready handshake.
// SEQ_DETECT_OVERLAP_EN selects overlapping matching; undefined = non-overlapping.
module seq_detect_ctrl #(
  parameter int          DATA_W  = 8,
  parameter logic [3:0]  PATTERN = 4'b1010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [4:0]        out_count,
  input  logic              out_ready,
  output logic              z,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    REPORT
  } state_e;

  localparam int            CW   = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);

  state_e            state_q;
  logic [DATA_W-1:0] sr_q;
  logic [CW-1:0]     bcnt_q;
  logic [3:0]        hist_q;
  logic [2:0]        hcnt_q;
  logic [4:0]        mcnt_q;
  logic              z_q;
  logic              ov_q;
  logic [4:0]        oc_q;

  logic [3:0] hist_d;
  logic [2:0] hcnt_d;
  logic       hit;

  // hcnt tracks bits seen since the last history clear, saturating at 4
  always_comb begin
    hist_d = {hist_q[2:0], sr_q[DATA_W-1]};
    hcnt_d = (hcnt_q == 3'd4) ? 3'd4 : hcnt_q + 3'd1;
    hit    = (hcnt_d == 3'd4) && (hist_d == PATTERN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bcnt_q  <= '0;
      hist_q  <= '0;
      hcnt_q  <= '0;
      mcnt_q  <= '0;
      z_q     <= 1'b0;
      ov_q    <= 1'b0;
      oc_q    <= '0;
    end else begin
      z_q <= 1'b0;
      if (z_q && mcnt_q != 5'd31) begin
        mcnt_q <= mcnt_q + 5'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sr_q    <= in_data;
            bcnt_q  <= '0;
            hist_q  <= '0;
            hcnt_q  <= '0;
            mcnt_q  <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (bcnt_q != LAST) begin
            sr_q   <= sr_q << 1;
            bcnt_q <= bcnt_q + 1'b1;
            z_q    <= hit;
`ifdef SEQ_DETECT_OVERLAP_EN
            hist_q <= hist_d;
            hcnt_q <= hcnt_d;
`else
            hist_q <= hit ? 4'd0 : hist_d;
            hcnt_q <= hit ? 3'd0 : hcnt_d;
`endif
          end else begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          ov_q    <= 1'b1;
          oc_q    <= mcnt_q;
          state_q <= REPORT;
        end
        REPORT: begin
          if (out_ready) begin
            ov_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = ov_q;
  assign out_count = oc_q;
  assign z         = z_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: expected counts queued at send,
// compared when out_valid appears; z checked per cycle against a model.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_count;
  logic       out_ready;
  logic       z;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;
  logic [4:0] sb[$];

  always #5 clk = ~clk;

  seq_detect_ctrl #(
    .DATA_W (8),
    .PATTERN(4'b1010)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_count(out_count),
    .out_ready(out_ready),
    .z        (z),
    .busy     (busy)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // zm[k] = 1 when z must be high after edge k (bit k completes a match)
  function automatic logic [4:0] model(input logic [7:0] w,
                                       output logic [8:0] zm);
    logic [3:0] h;
    int n;
    int c;
    zm = '0;
    h  = '0;
    n  = 0;
    c  = 0;
    for (int i = 7; i >= 0; i--) begin
      h = {h[2:0], w[i]};
      if (n < 4) n++;
      if (n == 4 && h == 4'b1010) begin
        c++;
        zm[8-i] = 1'b1;
`ifndef SEQ_DETECT_OVERLAP_EN
        h = '0;
        n = 0;
`endif
      end
    end
    return (c > 31) ? 5'd31 : 5'(c);
  endfunction

  task automatic run_word(input logic [7:0] w, input int hold);
    logic [8:0] zm;
    logic [4:0] exp_c;
    int k;
    sb.push_back(model(w, zm));
    @(negedge clk);
    check("in_ready_idle", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~w;
    k = 0;
    while (k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      in_valid = k[0];
      if (out_valid) break;
      check($sformatf("z_edge%0d", k), int'(z), (k <= 8) ? int'(zm[k]) : 0);
      check("busy_run", int'(busy), 1);
      check("in_ready_run", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    check("latency", k, 10);
    exp_c = sb.pop_front();
    check("out_count", int'(out_count), int'(exp_c));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_count", int'(out_count), int'(exp_c));
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", int'(out_valid), 0);
    check("busy_drop", int'(busy), 0);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_z", int'(z), 0);
    check("rst_busy", int'(busy), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    run_word(8'b10101010, 0);
    run_word(8'hFF, 0);
    run_word(8'h00, 0);
    run_word(8'b10101010, 5);
    run_word(8'b01011010, 2);
    run_word(8'b10100000, 0);
    for (int i = 0; i < 6; i++) begin
      run_word(8'($urandom_range(0, 255)), i % 3);
    end

    // abort a word mid-shift, then scan a fresh one
    sb.push_back(5'd0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'b10101010;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    run_word(8'b00001010, 0);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
